// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared command encoding and word widths for the SPI slave data path
package spi_pkg;

   localparam int RX_W = 10;
   localparam int TX_W = 8;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   // Command field sits in the two most significant bits of the slave word
   function automatic cmd_e decode_cmd(input logic [RX_W-1:0] word);
      return cmd_e'(word[RX_W-1 -: 2]);
   endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// rtl/ram_sp_sync.sv - single-port synchronous RAM with registered read and no array reset
module ram_sp_sync #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8,
   parameter int AW    = 8
)(
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write when enabled; the output register reads the addressed word every cycle (old data on a write)
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - command decoder and byte RAM downstream of the SPI slave
module spi_ram
   import spi_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [RX_W-1:0] rx_data,
   input  logic            rx_valid,
   output logic [TX_W-1:0] tx_data,
   output logic            tx_valid
);

   localparam int                   RAM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_SIZE:0]   DEPTH_V   = (ADDR_SIZE+1)'(MEM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

   // Extra top bit keeps the compare exact when MEM_DEPTH equals 2**ADDR_SIZE
   function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
      return {1'b0, a} < DEPTH_V;
   endfunction

   // Post-increment wraps at the last real word, not at the register width
   function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
   endfunction

   logic                 rx_valid_q;
   logic                 accept;
   cmd_e                 cmd;
   logic [ADDR_SIZE-1:0] payload_addr;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [ADDR_SIZE-1:0] hold_addr;
   logic [ADDR_SIZE-1:0] addr_sel;
   logic                 tx_zero;
   logic                 ram_we;
   logic [TX_W-1:0]      ram_dout;

   assign accept       = rx_valid & ~rx_valid_q;
   assign cmd          = decode_cmd(rx_data);
   assign payload_addr = rx_data[ADDR_SIZE-1:0];

   // RAM port steering: the accepted access gets the port, otherwise it keeps re-reading the last
   // read address so the registered output (and thus tx_data) holds until the next command
   always_comb begin
      ram_we   = 1'b0;
      addr_sel = hold_addr;
      if (accept) begin
         case (cmd)
            CMD_WR_DATA: begin
               addr_sel = wr_addr;
               ram_we   = in_range(wr_addr);
            end
            CMD_RD_DATA: addr_sel = rd_addr;
            default:     ;
         endcase
      end
   end

   // Edge detector, address registers and tx_valid control
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_valid_q <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         hold_addr  <= '0;
         tx_valid   <= 1'b0;
         tx_zero    <= 1'b1;
      end else begin
         rx_valid_q <= rx_valid;
         if (accept) begin
            tx_valid <= 1'b0;
            case (cmd)
               CMD_WR_ADDR: wr_addr <= payload_addr;
               CMD_WR_DATA: begin
                  if (AUTO_INC != 0) wr_addr <= next_addr(wr_addr);
               end
               CMD_RD_ADDR: rd_addr <= payload_addr;
               CMD_RD_DATA: begin
                  tx_valid  <= 1'b1;
                  tx_zero   <= ~in_range(rd_addr);
                  hold_addr <= rd_addr;
                  if (AUTO_INC != 0) rd_addr <= next_addr(rd_addr);
               end
               default: ;
            endcase
         end
      end
   end

   assign tx_data = tx_zero ? '0 : ram_dout;

   ram_sp_sync #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (TX_W),
      .AW    (RAM_AW)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (addr_sel[RAM_AW-1:0]),
      .din  (rx_data[TX_W-1:0]),
      .dout (ram_dout)
   );

endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - two-configuration bench for spi_ram against a behavioural model
module tb_spi_ram;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_valid;
   logic [9:0] rx_data;
   logic [7:0] a_tx_data, b_tx_data;
   logic       a_tx_valid, b_tx_valid;

   always #5 clk = ~clk;

   // dut_a: full depth with post-increment; dut_b: short depth, no increment
   spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut_a (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(a_tx_data), .tx_valid(a_tx_valid));

   spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(0)) dut_b (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(b_tx_data), .tx_valid(b_tx_valid));

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one view of memory and addresses per DUT configuration
   int         m_depth[2] = '{256, 200};
   bit         m_inc[2]   = '{1'b1, 1'b0};
   logic [7:0] m_mem[2][256];
   bit         m_known[2][256];
   int         m_wr[2];
   int         m_rd[2];
   bit         m_valid[2];
   logic [7:0] m_data[2];
   bit         m_dchk[2];
   bit         m_prev;

   function automatic int bump(input int a, input int depth);
      return (a + 1 == depth) ? 0 : (a + 1) % 256;
   endfunction

   task automatic model_step();
      int cmd;
      int p;
      if (rst === 1'b1) begin
         for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = 8'h00;
            m_dchk[d]  = 1'b1;
            m_wr[d]    = 0;
            m_rd[d]    = 0;
         end
         m_prev = 1'b0;
      end else begin
         if (rx_valid === 1'b1 && !m_prev) begin
            cmd = int'(rx_data[9:8]);
            p   = int'(rx_data[7:0]);
            for (int d = 0; d < 2; d++) begin
               m_valid[d] = 1'b0;
               m_dchk[d]  = 1'b0;
               case (cmd)
                  0: m_wr[d] = p;
                  1: begin
                     if (m_wr[d] < m_depth[d]) begin
                        m_mem[d][m_wr[d]]   = 8'(p);
                        m_known[d][m_wr[d]] = 1'b1;
                     end
                     if (m_inc[d]) m_wr[d] = bump(m_wr[d], m_depth[d]);
                  end
                  2: m_rd[d] = p;
                  default: begin
                     m_valid[d] = 1'b1;
                     if (m_rd[d] >= m_depth[d]) begin
                        m_data[d] = 8'h00;
                        m_dchk[d] = 1'b1;
                     end else begin
                        m_data[d] = m_mem[d][m_rd[d]];
                        m_dchk[d] = m_known[d][m_rd[d]];
                     end
                     if (m_inc[d]) m_rd[d] = bump(m_rd[d], m_depth[d]);
                  end
               endcase
            end
         end
         m_prev = (rx_valid === 1'b1);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle compare, away from the active edge
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("cyc_valid_a", 32'(a_tx_valid), 32'(m_valid[0]));
         if (m_dchk[0]) chk("cyc_data_a", 32'(a_tx_data), 32'(m_data[0]));
         chk("cyc_valid_b", 32'(b_tx_valid), 32'(m_valid[1]));
         if (m_dchk[1]) chk("cyc_data_b", 32'(b_tx_data), 32'(m_data[1]));
      end
   end

   task automatic send(input logic [9:0] w, input int hold, input int gap, input bit churn);
      @(negedge clk);
      rx_data  = w;
      rx_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (churn) rx_data = 10'($urandom);
      end
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic cmd12(input logic [9:0] w);
      send(w, 12, 2, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [7:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 8'($urandom_range(0, 7));
         1:       return 8'($urandom_range(8'hC4, 8'hCB));
         2:       return 8'($urandom_range(8'hF8, 8'hFF));
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      logic [1:0] c;
      logic [7:0] p;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = '0;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Reset state
      chk("rst_valid_a", 32'(a_tx_valid), 32'd0);
      chk("rst_data_a",  32'(a_tx_data),  32'h00);
      chk("rst_valid_b", 32'(b_tx_valid), 32'd0);
      chk("rst_data_b",  32'(b_tx_data),  32'h00);

      // Basic transaction with one-cycle read latency and hold
      cmd12(10'h012);
      cmd12(10'h1A5);
      cmd12(10'h212);
      @(negedge clk);
      chk("t2_pre_valid_a", 32'(a_tx_valid), 32'd0);
      rx_data  = 10'h300;
      rx_valid = 1'b1;
      @(negedge clk);
      chk("t2_lat_valid_a", 32'(a_tx_valid), 32'd1);
      chk("t2_lat_data_a",  32'(a_tx_data),  32'hA5);
      chk("t2_lat_data_b",  32'(b_tx_data),  32'hA5);
      repeat (11) @(negedge clk);
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("t2_hold_valid_b", 32'(b_tx_valid), 32'd1);
      chk("t2_hold_data_b",  32'(b_tx_data),  32'hA5);

      // Held level executes once; wr_addr moves to 1 on the incrementing DUT
      cmd12(10'h000);
      send(10'h177, 6, 2, 1'b0);
      chk("t3_model_wr_a",  32'(m_wr[0]),     32'd1);
      chk("t3_model_mem_a", 32'(m_mem[0][0]), 32'h77);
      cmd12(10'h188);
      cmd12(10'h200);
      cmd12(10'h300);
      chk("t3_rd0_a", 32'(a_tx_data), 32'h77);
      chk("t3_rd0_b", 32'(b_tx_data), 32'h88);
      cmd12(10'h300);
      chk("t3_rd1_a", 32'(a_tx_data), 32'h88);

      // Wrap at the top of a full-depth memory
      cmd12(10'h0FF);
      cmd12(10'h111);
      cmd12(10'h122);
      chk("t4_model_ff_a", 32'(m_mem[0][255]), 32'h11);
      chk("t4_model_00_a", 32'(m_mem[0][0]),   32'h22);
      cmd12(10'h2FF);
      cmd12(10'h300);
      chk("t4_rd_ff_a", 32'(a_tx_data), 32'h11);
      chk("t4_rd_ff_b", 32'(b_tx_data), 32'h00);
      cmd12(10'h300);
      chk("t4_rd_00_a", 32'(a_tx_data), 32'h22);

      // Out of range on the 200-deep DUT
      cmd12(10'h0D0);
      cmd12(10'h155);
      cmd12(10'h2D0);
      cmd12(10'h300);
      chk("t5_model_nowr_b", 32'(m_known[1][8'hD0]), 32'd0);
      chk("t5_valid_b", 32'(b_tx_valid), 32'd1);
      chk("t5_data_b",  32'(b_tx_data),  32'h00);
      chk("t5_data_a",  32'(a_tx_data),  32'h55);

      // Reset during a held read; memory survives, addresses return to 0
      cmd12(10'h012);
      cmd12(10'h1A5);
      cmd12(10'h212);
      cmd12(10'h300);
      chk("t6_pre_data_a", 32'(a_tx_data), 32'hA5);
      pulse_reset();
      chk("t6_rst_valid_a", 32'(a_tx_valid), 32'd0);
      chk("t6_rst_data_a",  32'(a_tx_data),  32'h00);
      chk("t6_rst_valid_b", 32'(b_tx_valid), 32'd0);
      chk("t6_model_rd_a",  32'(m_rd[0]),    32'd0);
      cmd12(10'h300);
      chk("t6_rd_addr0_a", 32'(a_tx_data), 32'h22);
      chk("t6_rd_addr0_b", 32'(b_tx_data), 32'h88);
      cmd12(10'h212);
      cmd12(10'h300);
      chk("t6_keep_a", 32'(a_tx_data), 32'hA5);
      chk("t6_keep_b", 32'(b_tx_data), 32'hA5);

      // Randomised traffic: commands, varying hold/gap, payload churn while held, occasional reset
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            pulse_reset();
         end else begin
            c = 2'($urandom_range(0, 3));
            p = (c == 2'b00 || c == 2'b10) ? pick_addr() : 8'($urandom_range(0, 255));
            send({c, p}, $urandom_range(1, 10), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
         end
      end
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
